// File: rtl/fifo_gray.sv
// Single-clock stream FIFO for buffering between CNN pipeline stages.
// Pointers carry a wrap bit and a Gray copy. Full and empty come from comparing
// the Gray pointers. Occupancy is exported in Gray code for status monitoring.
module fifo_gray #(
    parameter int unsigned ADDR_BIT = 4,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ren,
    input  logic                wen,
    input  logic [WIDTH-1:0]    in,
    output logic [WIDTH-1:0]    out,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic [ADDR_BIT:0]   gray_count
);

    localparam int unsigned DEPTH = 1 << ADDR_BIT;
    localparam int unsigned PW    = ADDR_BIT + 1;

    // XOR mask that inverts the two MSBs of a Gray pointer. Built as a shifted
    // constant so it also works for ADDR_BIT == 1.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wgray;
    logic [PW-1:0] rgray;
    logic [PW-1:0] count;
    logic          do_write;
    logic          do_read;

    // Gray copies of the pointers, the occupancy, and the status flags
    always_comb begin
        wgray       = wptr ^ (wptr >> 1);
        rgray       = rptr ^ (rptr >> 1);
        count       = wptr - rptr;
        empty       = (wgray == rgray);
        full        = (wgray == (rgray ^ FULL_MASK));
        almost_full = (count >= AF_LEVEL);
        gray_count  = count ^ (count >> 1);
        do_write    = wen & ~full;
        do_read     = ren & ~empty;
    end

    // Storage array. It has no reset because its contents do not matter until written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr[ADDR_BIT-1:0]] <= in;
        end
    end

    // Write pointer. It advances only on an accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
        end else if (do_write) begin
            wptr <= wptr + PW'(1);
        end
    end

    // Read pointer and registered read data. out holds its value when no pop occurs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr <= '0;
            out  <= '0;
        end else if (do_read) begin
            rptr <= rptr + PW'(1);
            out  <= mem[rptr[ADDR_BIT-1:0]];
        end
    end

endmodule

// File: tb/tb_fifo_gray.sv
// Randomised and directed bench for fifo_gray. It checks the DUT against a
// queue-based reference model.
module tb_fifo_gray;

    localparam int unsigned ADDR_BIT = 4;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 1 << ADDR_BIT;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                ren = 1'b0;
    logic                wen = 1'b0;
    logic [WIDTH-1:0]    din = '0;
    logic [WIDTH-1:0]    dout;
    logic                empty;
    logic                full;
    logic                almost_full;
    logic [ADDR_BIT:0]   gray_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_out = '0;

    fifo_gray #(.ADDR_BIT(ADDR_BIT), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ren         (ren),
        .wen         (wen),
        .in          (din),
        .out         (dout),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .gray_count  (gray_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reflected-binary code, built up one bit at a time from the top
    function automatic logic [31:0] to_gray(input int unsigned n);
        logic [31:0] g;
        int unsigned b;
        g = '0;
        for (int i = 31; i >= 0; i--) begin
            b = (n >> i) & 1;
            if (i == 31) g[i] = b[0];
            else         g[i] = b[0] ^ ((n >> (i + 1)) & 1) ? 1'b1 : 1'b0;
        end
        return g;
    endfunction

    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, ".out"},   32'(dout),        32'(exp_out));
        check({tag, ".empty"}, 32'(empty),       32'(n == 0));
        check({tag, ".full"},  32'(full),        32'(n == DEPTH));
        check({tag, ".afull"}, 32'(almost_full), 32'(n >= DEPTH - 1));
        check({tag, ".gcnt"},  32'(gray_count),  to_gray(n));
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check at next negedge
    task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
        bit wr_ok, rd_ok;
        wen = w; ren = r; din = d;
        @(posedge clk);
        wr_ok = w && (q.size() < DEPTH);
        rd_ok = r && (q.size() > 0);
        if (rd_ok) exp_out = q.pop_front();
        if (wr_ok) q.push_back(d);
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] v;

        // Reset held, then released
        @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // Fill past capacity
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0, WIDTH'(i), "fill");
            if (i == 15) begin
                check("fill15.afull", 32'(almost_full), 32'd1);
                check("fill15.gcnt",  32'(gray_count),  32'b01000);
            end
            if (i == 16) begin
                check("fill16.full", 32'(full),       32'd1);
                check("fill16.gcnt", 32'(gray_count), 32'b11000);
            end
        end

        // Drain past empty
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b1, '0, "drain");
            if (i <= 16) check("drain.data", 32'(dout), 32'(i));
            else         check("drain.hold", 32'(dout), 32'd16);
        end
        check("drain.gcnt0", 32'(gray_count), 32'd0);

        // Wrap-around across the end of the address space
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, WIDTH'(8'h40 + i), "wrap_w1");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0, "wrap_r1");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, WIDTH'(8'h80 + i), "wrap_w2");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, '0, "wrap_r2");
            check("wrap.data", 32'(dout), 32'(8'h80 + i));
        end

        // Simultaneous read and write at occupancy 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, WIDTH'(8'hA0 + i), "sim_fill");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, WIDTH'(8'hB0 + i), "sim_rw");
            check("sim.gcnt5", 32'(gray_count), 32'b00111);
        end
        while (q.size() > 0) cycle(1'b0, 1'b1, '0, "sim_drain");

        // Simultaneous read and write while empty: only the write happens
        v = dout;
        cycle(1'b1, 1'b1, 8'h5A, "sim_empty");
        check("sim_empty.gcnt1", 32'(gray_count), 32'd1);
        check("sim_empty.hold",  32'(dout),       32'(v));
        cycle(1'b0, 1'b1, '0, "sim_empty_rd");

        // A pulse between edges has no effect
        #2 wen = 1'b1; din = 8'hEE;
        #2 wen = 1'b0;
        @(negedge clk);
        check_all("glitch");

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom), 1'($urandom), WIDTH'($urandom), "rand");
        end

        // Asynchronous reset between edges at occupancy 7
        while (q.size() > 0) cycle(1'b0, 1'b1, '0, "pre_ar_drain");
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, WIDTH'(8'hC0 + i), "ar_fill");
        cycle(1'b0, 1'b1, '0, "ar_rd");
        cycle(1'b1, 1'b0, 8'hCF, "ar_fill2");
        #2 rst = 1'b0;
        #1;
        check("async.empty", 32'(empty),      32'd1);
        check("async.gcnt",  32'(gray_count), 32'd0);
        check("async.out",   32'(dout),       32'd0);
        check("async.full",  32'(full),       32'd0);
        q.delete();
        exp_out = '0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'h33, "post_ar_w");
        cycle(1'b0, 1'b1, '0, "post_ar_r");
        check("post_ar.data", 32'(dout), 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_gray.md
Name: fifo_gray

Overview:
- Single-clock, synchronous-write/synchronous-read FIFO with parameterised width and power-of-two depth.
- Used as a stream buffer between CNN pipeline stages.
- Read and write pointers are kept internally in binary and Gray form. Full/empty are derived by Gray-pointer comparison.
- Exports the occupancy count in Gray code for status monitoring.

Parameters:
- ADDR_BIT, 4, address width; DEPTH = 2**ADDR_BIT entries (16 by default).
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- ren  input  1  read enable (single-cycle pop request).
- wen  input  1  write enable (single-cycle push request).
- in  input  WIDTH  write data.
- out  output  WIDTH  read data (registered).
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- almost_full  output  1  FIFO holds >= DEPTH-1 entries.
- gray_count  output  ADDR_BIT+1  occupancy count (0..DEPTH) in binary-reflected Gray code.

Behaviour:
- Storage: DEPTH x WIDTH memory array.
- Pointers: wptr and rptr are ADDR_BIT+1 bits. The low ADDR_BIT bits address memory; the MSB is the wrap bit. Each pointer is kept with a Gray copy, g = b ^ (b >> 1).
- Reset (rst=0, asynchronous):
  - wptr = rptr = 0, out = 0, empty = 1.
  - full = 0, almost_full = 0, gray_count = 0.
  - Memory contents are don't-care.
- Write: on posedge clk with wen=1 and full=0:
  - mem[wptr[ADDR_BIT-1:0]] <= in.
  - wptr increments.
  - A write while full is ignored; no data is corrupted.
- Read: on posedge clk with ren=1 and empty=0:
  - out <= mem[rptr[ADDR_BIT-1:0]]; new data is visible after that edge (1-cycle latency).
  - rptr increments.
  - A read while empty is ignored and out holds its value.
- out holds its last value whenever no valid read occurs.
- empty = (wgray == rgray).
- full = wgray equals rgray with its two MSBs inverted and remaining bits equal (i.e. binary count == DEPTH).
- count = wptr - rptr (modulo 2^(ADDR_BIT+1)), range 0..DEPTH.
- gray_count = count ^ (count >> 1).
- almost_full = (count >= DEPTH-1).
- All flags and gray_count are combinational from the registered pointers, so they update in the same cycle the pointers change.
- Simultaneous wen and ren:
  - Not empty and not full: both occur; count is unchanged.
  - Empty: only the write occurs.
  - Full: only the read occurs; the write is dropped.
- Wrap-around: pointers wrap naturally modulo 2^(ADDR_BIT+1); the MSB differentiates full from empty.
- Reset mid-operation: pointers and flags clear immediately without waiting for a clock edge; queued data is discarded.
- Inputs are sampled only at rising edges; pulses on wen/ren between edges have no effect.

Test Plan:
- Reset: hold rst=0 -> empty=1, full=0, almost_full=0, gray_count=0, out=0. Release rst=1 -> outputs unchanged.
- Fill past capacity (DEPTH=16):
  - Write values 1..20, one per cycle.
  - After 15 writes: almost_full=1, gray_count=Gray(15)=01000.
  - After 16 writes: full=1, gray_count=Gray(16)=11000.
  - Writes 17..20 are dropped; count stays 16.
- Drain:
  - Issue 20 reads -> out yields 1,2,...,16 on successive read edges.
  - full clears after the first read; empty=1 after the 16th read.
  - Reads 17..20 are ignored; out stays 16 and gray_count returns to 0.
- Wrap-around:
  - Write 10, read 10, then write 10 more (crossing address 15->0).
  - Read back -> data in order; empty and full are correct throughout.
- Simultaneous R/W:
  - Occupancy 5 with wen=ren=1 for 8 cycles -> count stays 5 and data order is preserved.
  - At occupancy 0 with wen=ren=1 -> count becomes 1 and out is unchanged.
- Async reset mid-stream: assert rst=0 between clock edges at occupancy 7 -> empty=1 and gray_count=0 immediately, before the next edge.
